bit_popcount_seq: RTL and testbench

BIT_POPCOUNT_SEQ -- requirements
Module: bit_popcount_seq

---
 rtl/bit_popcount_seq_if.sv | 36 +++
 rtl/bit_popcount_seq.sv | 151 +++++++++++++++
 tb/tb_bit_popcount_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_popcount_seq_if.sv
// Handshake and result bundle for bit_popcount_seq.
// When BIT_POPCOUNT_SEQ_FIRST_EN is defined, the first-match result
// signals (first_idx, found) are added to the bundle.
interface bit_popcount_seq_if #(
  parameter int WIDTH = 256,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
`ifdef BIT_POPCOUNT_SEQ_FIRST_EN
  logic [CW-1:0]    first_idx;
  logic             found;
`endif

  // Requester side: issues operations and observes the result.
  modport master (
    output start, mode, in,
`ifdef BIT_POPCOUNT_SEQ_FIRST_EN
    input  first_idx, found,
`endif
    input  busy, done, count
  );

  // Counter side.
  modport slave (
    input  start, mode, in,
`ifdef BIT_POPCOUNT_SEQ_FIRST_EN
    output first_idx, found,
`endif
    output busy, done, count
  );
endinterface

// File: rtl/bit_popcount_seq.sv
// Sequential population counter: examines a WIDTH-bit operand SLICE bits
// per clock and reports the number of ones (mode=0) or zeros (mode=1).
// Optional feature macro BIT_POPCOUNT_SEQ_FIRST_EN adds the lowest
// matching bit index (first_idx) and a match flag (found).
//
// state | meaning
// IDLE  | waiting for start; count holds the last result
// RUN   | one slice of the shift register consumed per cycle
// DONE  | publish accumulator to count, pulse done, return to IDLE
module bit_popcount_seq #(
  parameter int WIDTH = 256,
  parameter int SLICE = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_popcount_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int SCW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PW     = $clog2(SLICE + 1);
  localparam logic [SCW-1:0] LAST_SLICE = SCW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             mode_r;
  logic [CW-1:0]    acc;
  logic [SCW-1:0]   slice_cnt;
  logic             busy_r;
  logic             done_r;
  logic [CW-1:0]    count_r;
  logic [PW-1:0]    slice_pop;

  // Count the bits of the current slice that match the captured target
  // (a bit matches when it differs from mode: ones for mode=0, zeros for mode=1).
  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < SLICE; i++) begin
      slice_pop = slice_pop + PW'(shreg[i] ^ mode_r);
    end
  end

  // Sequencing FSM with registered busy/done/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      mode_r    <= 1'b0;
      acc       <= '0;
      slice_cnt <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      count_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg     <= bus.in;
            mode_r    <= bus.mode;
            acc       <= '0;
            slice_cnt <= '0;
            busy_r    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc   <= acc + CW'(slice_pop);
          shreg <= shreg >> SLICE;
          if (slice_cnt == LAST_SLICE) begin
            busy_r <= 1'b0;
            state  <= DONE;
          end else begin
            slice_cnt <= slice_cnt + SCW'(1);
          end
        end
        DONE: begin
          count_r <= acc;
          done_r  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.count = count_r;

`ifdef BIT_POPCOUNT_SEQ_FIRST_EN
  logic          slice_hit;
  logic [CW-1:0] slice_pos;
  logic          hit_r;
  logic [CW-1:0] pos_r;
  logic          found_r;
  logic [CW-1:0] first_idx_r;

  // Lowest matching bit within the current slice; scanning downward lets
  // the lowest index win.
  always_comb begin
    slice_hit = 1'b0;
    slice_pos = '0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (shreg[i] ^ mode_r) begin
        slice_hit = 1'b1;
        slice_pos = CW'(i);
      end
    end
  end

  // Track the first match across slices and publish it alongside count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r       <= 1'b0;
      pos_r       <= '0;
      found_r     <= 1'b0;
      first_idx_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            hit_r <= 1'b0;
            pos_r <= '0;
          end
        end
        RUN: begin
          if (!hit_r && slice_hit) begin
            hit_r <= 1'b1;
            pos_r <= CW'(slice_cnt) * CW'(SLICE) + slice_pos;
          end
        end
        DONE: begin
          found_r     <= hit_r;
          first_idx_r <= pos_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.found     = found_r;
  assign bus.first_idx = first_idx_r;
`endif
endmodule

// File: tb/tb_bit_popcount_seq.sv
// Scoreboard bench for bit_popcount_seq: a driver issues operations and
// pushes reference results; a monitor checks every cycle after the clock.
module tb_bit_popcount_seq;
  localparam int W  = 256;
  localparam int S  = 8;
  localparam int CW = $clog2(W + 1);
  localparam int NS = W / S;

  typedef struct {
    int     cnt;
    int     idx;
    bit     fnd;
    longint due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  longint edge_no = 0;
  int     total = 0;
  int     bad = 0;

  exp_t   exp_q[$];
  longint next_ok = 0;
  longint act_edge = -1;
  int     model_count = 0;
  int     model_idx = 0;
  bit     model_fnd = 1'b0;

  bit_popcount_seq_if #(.WIDTH(W), .CW(CW)) bif ();

  bit_popcount_seq #(.WIDTH(W), .SLICE(S), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no = edge_no + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  // Reference: count by the plain definition, scan for the lowest match.
  function automatic exp_t ref_op(input logic md, input logic [W-1:0] v, input longint due);
    exp_t e;
    e.cnt = 0;
    e.idx = 0;
    e.fnd = 1'b0;
    e.due = due;
    for (int i = 0; i < W; i++) begin
      if (v[i] == !md) begin
        e.cnt++;
        if (!e.fnd) begin
          e.fnd = 1'b1;
          e.idx = i;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    int dens;
    dens = $urandom_range(0, 3);
    for (int i = 0; i < W; i++) begin
      case (dens)
        0: v[i] = ($urandom_range(0, 31) == 0);
        1: v[i] = ($urandom_range(0, 31) != 0);
        default: v[i] = $urandom_range(0, 1);
      endcase
    end
    return v;
  endfunction

  // One clock of stimulus; the model decides whether the next edge accepts.
  task automatic cycle(input logic st, input logic md, input logic [W-1:0] v);
    longint e;
    @(negedge clk);
    bif.start = st;
    bif.mode  = md;
    bif.in    = v;
    e = edge_no + 1;
    if (st && rst_n && e >= next_ok) begin
      exp_q.push_back(ref_op(md, v, e + NS + 1));
      act_edge = e;
      next_ok  = e + NS + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 1), rand_vec());
  endtask

  // Issue one operation; optionally scramble start/mode/in while it runs.
  task automatic run_op(input logic md, input logic [W-1:0] v, input bit scramble);
    while (edge_no + 1 < next_ok) idle(1);
    cycle(1'b1, md, v);
    for (int i = 0; i < NS + 1; i++) begin
      if (scramble) cycle(1'b1, $urandom_range(0, 1), rand_vec());
      else cycle(1'b0, md, v);
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    act_edge    = -1;
    model_count = 0;
    model_idx   = 0;
    model_fnd   = 1'b0;
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_count", bif.count, 0);
    repeat (hold) @(negedge clk);
    rst_n   = 1'b1;
    next_ok = edge_no + 1;
  endtask

  // Monitor: pops the scoreboard on done and checks outputs every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bif.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (edge %0d)", edge_no);
        end else begin
          e = exp_q.pop_front();
          chk("done_edge", 64'(edge_no), 64'(e.due));
          model_count = e.cnt;
          model_idx   = e.idx;
          model_fnd   = e.fnd;
        end
      end else if (exp_q.size() > 0 && edge_no >= exp_q[0].due) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_done: got done=%b expected 1 (edge %0d)", bif.done, edge_no);
      end
      chk("count", bif.count, 64'(model_count));
      chk("busy", bif.busy, 64'(act_edge >= 0 && edge_no >= act_edge && edge_no < act_edge + NS));
`ifdef BIT_POPCOUNT_SEQ_FIRST_EN
      chk("first_idx", bif.first_idx, 64'(model_idx));
      chk("found", bif.found, 64'(model_fnd));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    bif.start = 1'b0;
    bif.mode  = 1'b0;
    bif.in    = '0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    do_reset(2);

    run_op(1'b0, '0, 1'b0);
    run_op(1'b0, '1, 1'b0);
    run_op(1'b1, '1, 1'b0);
    v = '0; v[W-1] = 1'b1; v[0] = 1'b1;
    run_op(1'b0, v, 1'b0);
    v = '0; v[W-1] = 1'b1;
    run_op(1'b1, v, 1'b0);
    v = '0; v[7:4] = 4'hF;
    run_op(1'b0, v, 1'b1);

    // Abort mid-run, then confirm no stale done and a clean restart.
    while (edge_no + 1 < next_ok) idle(1);
    cycle(1'b1, 1'b0, '1);
    idle(10);
    do_reset(2);
    idle(40);
    v = '0; v[1:0] = 2'b11;
    run_op(1'b0, v, 1'b0);

    // Start held high: back-to-back operations.
    v = '0; v[2] = 1'b1; v[0] = 1'b1;
    for (int i = 0; i < 3 * (NS + 2); i++) cycle(1'b1, 1'b0, v);
    idle(NS + 4);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < NS + 2 + $urandom_range(0, 6); i++)
        cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1), rand_vec());
    end
    idle(NS + 4);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
